// File: rtl/i2c_host_engine.sv
// Single-master I2C host: turns one parallel request into a complete
// register write or register read transaction on open-drain SCL/SDA.
// Every bus step is four SCL quarters of CLK_DIV cycles each.
module i2c_host_engine #(
    parameter int CLK_DIV = 25
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start_req,
    input  logic       rw,
    input  logic [6:0] dev_addr,
    input  logic [7:0] reg_addr,
    input  logic [7:0] wdata,
    input  logic       sda_in,
    output logic       scl_low,
    output logic       sda_low,
    output logic       busy,
    output logic       done,
    output logic       ack_err,
    output logic [7:0] rdata
);
    typedef enum logic [2:0] {
        S_IDLE, S_START, S_TX, S_RESTART, S_RX, S_STOP, S_DONE
    } state_t;

    localparam logic [7:0] QMAX = 8'(CLK_DIV - 1);

    state_t     state, state_nx;
    logic [7:0] qcnt;
    logic [1:0] phase;
    logic [3:0] bit_cnt;    // 0..7 data bits, 8 = ACK slot
    logic [1:0] step;       // 0 addr+W, 1 reg, 2 wdata, 3 addr+R
    logic       rw_q;
    logic [6:0] dev_q;
    logic [7:0] reg_q, wdata_q, tx_sh, rx_sh;
    logic       q_last, bit_end, byte_end, active;

    assign q_last   = (qcnt == QMAX);
    assign bit_end  = q_last && (phase == 2'd3);
    assign byte_end = bit_end && (bit_cnt == 4'd8);
    assign active   = (state != S_IDLE) && (state != S_DONE);
    assign busy     = active;
    assign done     = (state == S_DONE);

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nx;
    end

    // Quarter counter and q0..q3 phase; held at zero outside a transaction
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            qcnt  <= '0;
            phase <= '0;
        end else if (!active) begin
            qcnt  <= '0;
            phase <= '0;
        end else if (q_last) begin
            qcnt  <= '0;
            phase <= phase + 2'd1;
        end else begin
            qcnt  <= qcnt + 8'd1;
        end
    end

    // Request latch, byte shifters, bit/step sequencing, status
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rw_q    <= 1'b0;
            dev_q   <= '0;
            reg_q   <= '0;
            wdata_q <= '0;
            tx_sh   <= '0;
            rx_sh   <= '0;
            bit_cnt <= '0;
            step    <= '0;
            ack_err <= 1'b0;
            rdata   <= '0;
        end else begin
            if (state == S_IDLE && start_req) begin
                rw_q    <= rw;
                dev_q   <= dev_addr;
                reg_q   <= reg_addr;
                wdata_q <= wdata;
                tx_sh   <= {dev_addr, 1'b0};
                step    <= '0;
                bit_cnt <= '0;
                ack_err <= 1'b0;
            end
            if ((state == S_TX || state == S_RX) && bit_end) begin
                if (bit_cnt == 4'd8) bit_cnt <= '0;
                else                 bit_cnt <= bit_cnt + 4'd1;
            end
            if (state == S_TX && bit_end) begin
                if (bit_cnt == 4'd8) begin
                    // ACK slot: queue the next byte; a read reloads at RESTART
                    step  <= step + 2'd1;
                    tx_sh <= (step == 2'd0) ? reg_q : wdata_q;
                    if (sda_in) ack_err <= 1'b1;
                end else begin
                    tx_sh <= {tx_sh[6:0], 1'b0};
                end
            end
            if (state == S_RESTART && bit_end) begin
                tx_sh <= {dev_q, 1'b1};
                step  <= 2'd3;
            end
            if (state == S_RX && bit_end && bit_cnt < 4'd8) begin
                rx_sh <= {rx_sh[6:0], sda_in};
                if (bit_cnt == 4'd7) rdata <= {rx_sh[6:0], sda_in};
            end
        end
    end

    // Next state and bus drive; SDA only moves while SCL is held low
    // except for the START/RESTART/STOP conditions
    always_comb begin
        state_nx = state;
        scl_low  = 1'b0;
        sda_low  = 1'b0;
        case (state)
            S_IDLE: begin
                if (start_req) state_nx = S_START;
            end
            S_START: begin
                sda_low = phase[1];
                scl_low = (phase == 2'd3);
                if (bit_end) state_nx = S_TX;
            end
            S_TX: begin
                scl_low = ~phase[1];
                sda_low = (bit_cnt == 4'd8) ? 1'b0 : ~tx_sh[7];
                if (byte_end) begin
                    if (sda_in) state_nx = S_STOP;
                    else begin
                        case (step)
                            2'd0:    state_nx = S_TX;
                            2'd1:    state_nx = rw_q ? S_RESTART : S_TX;
                            2'd2:    state_nx = S_STOP;
                            default: state_nx = S_RX;
                        endcase
                    end
                end
            end
            S_RESTART: begin
                scl_low = (phase == 2'd0) || (phase == 2'd3);
                sda_low = phase[1];
                if (bit_end) state_nx = S_TX;
            end
            S_RX: begin
                // Slave drives data; the 9th bit is left released as NACK
                scl_low = ~phase[1];
                if (byte_end) state_nx = S_STOP;
            end
            S_STOP: begin
                scl_low = (phase == 2'd0);
                sda_low = (phase != 2'd3);
                if (bit_end) state_nx = S_DONE;
            end
            S_DONE: begin
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_i2c_host_engine.sv
// Bench for i2c_host_engine: behavioural I2C slave at 0x20 on a wired-AND
// bus, a protocol monitor, a directed vector table and randomized traffic
// checked against a register-map reference model.
module tb_i2c_host_engine;
    localparam int         D   = 4;
    localparam logic [6:0] SLV = 7'h20;

    logic       clock = 1'b0, reset = 1'b1;
    logic       start_req = 1'b0, rw_i = 1'b0;
    logic [6:0] dev_i = '0;
    logic [7:0] reg_i = '0, wdata_i = '0;
    logic       sda_in, scl_line;
    logic       scl_low, sda_low, busy, done, ack_err;
    logic [7:0] rdata;
    logic       slv_low = 1'b0;

    int errors = 0, checks = 0;

    always #5 clock = ~clock;

    assign scl_line = ~scl_low;
    assign sda_in   = ~(sda_low | slv_low);

    i2c_host_engine #(.CLK_DIV(D)) dut (
        .clock(clock), .reset(reset), .start_req(start_req), .rw(rw_i),
        .dev_addr(dev_i), .reg_addr(reg_i), .wdata(wdata_i), .sda_in(sda_in),
        .scl_low(scl_low), .sda_low(sda_low), .busy(busy), .done(done),
        .ack_err(ack_err), .rdata(rdata)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_lat(input string name, input int act, input int exp);
        checks++;
        if (act < exp - 1 || act > exp + 1) begin
            errors++;
            $display("FAIL %s: got %0d cycles expected %0d +/-1", name, act, exp);
        end
    endtask

    // ---------------- slave model + protocol monitor ----------------
    logic       scl_p = 1'b1, sda_p = 1'b1;
    logic       s_act = 1'b0, s_tx = 1'b0, s_rd = 1'b0, s_mack = 1'b0, armed = 1'b0;
    int         s_bit = 0, s_idx = 0, hcnt = 0, starts = 0, stops = 0, done_cnt = 0;
    logic [7:0] s_sh = '0, s_tx_sh = '0, s_ptr = '0;
    logic [7:0] sregs [256];
    logic [7:0] model_regs [256];
    logic [7:0] bus_q [$];

    initial begin : slave_mon
        logic scl, sda, ack;
        for (int i = 0; i < 256; i++) sregs[i] = 8'h00;
        forever begin
            @(negedge clock);
            scl = scl_line;
            sda = sda_in;
            if (done) done_cnt++;
            if (reset) begin
                s_act = 1'b0; slv_low = 1'b0; armed = 1'b0;
            end else if (scl_p && scl && sda_p && !sda) begin
                starts++;
                s_act = 1'b1; s_bit = 0; s_idx = 0; s_tx = 1'b0; s_rd = 1'b0;
            end else if (scl_p && scl && !sda_p && sda) begin
                stops++;
                s_act = 1'b0; slv_low = 1'b0; armed = 1'b0;
            end else if (!scl_p && scl) begin
                armed = busy;
                hcnt  = 0;
                if (s_act) begin
                    if (s_bit < 8 && !s_tx) s_sh = {s_sh[6:0], sda};
                    if (s_bit == 8 && s_tx) s_mack = !sda;
                    s_bit++;
                end
            end else if (scl_p && !scl) begin
                if (armed) check("scl_high_len", hcnt, 2 * D);
                armed = 1'b0;
                if (s_act) begin
                    if (s_bit == 8) begin
                        if (!s_tx) begin
                            bus_q.push_back(s_sh);
                            ack = 1'b1;
                            if (s_idx == 0) begin
                                ack  = (s_sh[7:1] == SLV);
                                s_rd = s_sh[0];
                            end else if (s_idx == 1) begin
                                s_ptr = s_sh;
                            end else begin
                                sregs[s_ptr] = s_sh;
                                s_ptr++;
                            end
                            s_idx++;
                            slv_low = ack;
                            if (!ack) s_act = 1'b0;
                        end else begin
                            slv_low = 1'b0;
                        end
                    end else if (s_bit == 9) begin
                        s_bit = 0;
                        if (!s_tx && s_rd) begin
                            s_tx    = 1'b1;
                            s_tx_sh = sregs[s_ptr];
                            slv_low = !s_tx_sh[7];
                        end else if (s_tx) begin
                            s_act = 1'b0; slv_low = 1'b0;
                        end else begin
                            slv_low = 1'b0;
                        end
                    end else if (s_tx) begin
                        slv_low = !s_tx_sh[7 - s_bit];
                    end
                end
            end
            if (scl) hcnt++;
            scl_p = scl;
            sda_p = sda;
        end
    end

    // ---------------- one transaction, with bus-level checks ----------------
    task automatic run_txn(input logic r, input logic [6:0] dv, input logic [7:0] rg,
                           input logic [7:0] wd, input int glitch_at,
                           output int lat, output logic err, output logic [7:0] rd);
        int n, s0, p0, d0;
        logic [7:0] exp_q [$];
        logic acked;
        acked = (dv == SLV);
        exp_q.push_back({dv, 1'b0});
        if (acked) begin
            exp_q.push_back(rg);
            if (r) exp_q.push_back({dv, 1'b1});
            else   exp_q.push_back(wd);
        end
        bus_q.delete();
        s0 = starts; p0 = stops; d0 = done_cnt;
        @(negedge clock);
        start_req = 1'b1; rw_i = r; dev_i = dv; reg_i = rg; wdata_i = wd;
        @(negedge clock);
        start_req = 1'b0;
        n = 1;
        check("busy_on_accept", busy, 1);
        check("ack_err_cleared", ack_err, 0);
        while (!done && n < 200 * D + 20) begin
            @(negedge clock);
            n++;
            start_req = (n == glitch_at);
            if (n == glitch_at) wdata_i = 8'h11;
        end
        check("done_seen", done, 1);
        lat = n - 1; err = ack_err; rd = rdata;
        @(negedge clock);
        start_req = 1'b0;
        check("done_one_cycle", done, 0);
        check("busy_after_done", busy, 0);
        repeat (4) @(negedge clock);
        check("done_pulses", done_cnt - d0, 1);
        check("start_conds", starts - s0, (acked && r) ? 2 : 1);
        check("stop_conds", stops - p0, 1);
        check("byte_count", bus_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < bus_q.size(); i++)
            check("bus_byte", bus_q[i], exp_q[i]);
        if (acked && !r) model_regs[rg] = wd;
    endtask

    typedef struct {
        logic       rw;
        logic [6:0] dev;
        logic [7:0] rg;
        logic [7:0] wd;
        logic       exp_err;
        logic [7:0] exp_rd;
        int         lat_mul;
    } vec_t;

    initial begin : main
        vec_t       vt [7];
        int         lat, e_lat;
        logic       err, r, acked, e_err;
        logic [7:0] rd, rg, wd, exp_rd, e_rd;
        logic [6:0] dv;

        vt[0] = '{1'b0, 7'h20, 8'h03, 8'hA5, 1'b0, 8'h00, 116};
        vt[1] = '{1'b1, 7'h20, 8'h03, 8'h00, 1'b0, 8'hA5, 156};
        vt[2] = '{1'b0, 7'h21, 8'h03, 8'h5A, 1'b1, 8'hA5,  44};
        vt[3] = '{1'b1, 7'h21, 8'h03, 8'h00, 1'b1, 8'hA5,  44};
        vt[4] = '{1'b0, 7'h20, 8'h00, 8'hFF, 1'b0, 8'hA5, 116};
        vt[5] = '{1'b1, 7'h20, 8'h00, 8'h00, 1'b0, 8'hFF, 156};
        vt[6] = '{1'b1, 7'h20, 8'h03, 8'h00, 1'b0, 8'hA5, 156};
        for (int i = 0; i < 256; i++) model_regs[i] = 8'h00;
        exp_rd = 8'h00;

        // reset state
        repeat (3) @(negedge clock);
        check("rst_scl_low", scl_low, 0);
        check("rst_sda_low", sda_low, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_ack_err", ack_err, 0);
        check("rst_rdata", rdata, 0);
        reset = 1'b0;
        repeat (3) @(negedge clock);

        // directed vectors
        for (int i = 0; i < 7; i++) begin
            run_txn(vt[i].rw, vt[i].dev, vt[i].rg, vt[i].wd, 0, lat, err, rd);
            check("vec_ack_err", err, vt[i].exp_err);
            check("vec_rdata", rd, vt[i].exp_rd);
            check_lat("vec_latency", lat, vt[i].lat_mul * D);
            exp_rd = vt[i].exp_rd;
        end

        // start_req while busy must not disturb the running write
        run_txn(1'b0, SLV, 8'h0A, 8'hA5, 100, lat, err, rd);
        check("busy_prot_ack_err", err, 0);
        run_txn(1'b1, SLV, 8'h0A, 8'h00, 0, lat, err, rd);
        check("busy_prot_readback", rd, 8'hA5);
        exp_rd = 8'hA5;

        // reset in the middle of bit 4 of the register byte
        @(negedge clock);
        start_req = 1'b1; rw_i = 1'b0; dev_i = SLV; reg_i = 8'h05; wdata_i = 8'h77;
        @(negedge clock);
        start_req = 1'b0;
        repeat (56 * D + 1) @(negedge clock);
        check("pre_reset_scl_low", scl_low, 1);
        check("pre_reset_sda_low", sda_low, 1);
        reset = 1'b1;
        #1;
        check("mid_reset_scl_low", scl_low, 0);
        check("mid_reset_sda_low", sda_low, 0);
        check("mid_reset_busy", busy, 0);
        check("mid_reset_rdata", rdata, 0);
        repeat (3) @(negedge clock);
        reset = 1'b0;
        exp_rd = 8'h00;
        run_txn(1'b0, SLV, 8'h05, 8'h3C, 0, lat, err, rd);
        check("post_reset_ack_err", err, 0);
        check_lat("post_reset_latency", lat, 116 * D);
        run_txn(1'b1, SLV, 8'h05, 8'h00, 0, lat, err, rd);
        check("post_reset_readback", rd, 8'h3C);
        exp_rd = 8'h3C;

        // randomized traffic against the register-map model
        for (int k = 0; k < 20; k++) begin
            r     = 1'($urandom_range(0, 1));
            dv    = ($urandom_range(0, 4) == 0) ? 7'h21 : SLV;
            rg    = 8'($urandom_range(0, 15));
            wd    = 8'($urandom);
            acked = (dv == SLV);
            e_err = !acked;
            e_rd  = (r && acked) ? model_regs[rg] : exp_rd;
            e_lat = (acked ? (r ? 156 : 116) : 44) * D;
            run_txn(r, dv, rg, wd, 0, lat, err, rd);
            check("rnd_ack_err", err, e_err);
            check("rnd_rdata", rd, e_rd);
            check_lat("rnd_latency", lat, e_lat);
            exp_rd = e_rd;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
